// File: rtl/ula_pkg.sv
// Shared definitions for the serial subtractor controller: FSM state
// encodings and the counter-width helper.
package ula_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of bits needed to count 0..value-1 (ceil(log2(value))).
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/FullSubtractor1Bit.sv
// One-bit full subtractor: S = A - B - Cin, Cout is the borrow out.
module FullSubtractor1Bit (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    // A borrow leaves this bit when B plus the incoming borrow exceeds A.
    assign Cout = (~A & B) | (~(A ^ B) & Cin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first,
// through a single 1-bit full subtractor. Result flags are registered and
// hold from the done pulse until the next accepted start.
module serial_subtractor_ctrl
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_nx_s;
    logic             accept_s;
    logic             last_bit_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [CNT_W-1:0] cnt_r;
    logic             borrow_r;
    logic [WIDTH-1:0] diff_r;
    logic             overflow_r;
    logic             zero_r;
    logic             busy_r;
    logic             done_r;

    logic             a_bit_s;
    logic             b_bit_s;
    logic             s_bit_s;
    logic             cout_s;
    logic [WIDTH-1:0] diff_nx_s;

    assign a_bit_s   = a_r[cnt_r];
    assign b_bit_s   = b_r[cnt_r];
    assign diff_nx_s = {s_bit_s, diff_r[WIDTH-1:1]};

    FullSubtractor1Bit u_fs (
        .A    (a_bit_s),
        .B    (b_bit_s),
        .Cin  (borrow_r),
        .S    (s_bit_s),
        .Cout (cout_s)
    );

    // Next-state logic: accept start only in IDLE, run WIDTH bits, pulse DONE.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        last_bit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s   = 1'b1;
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_BIT) begin
                    last_bit_s = 1'b1;
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register plus registered busy/done derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == RUN) || (state_nx_s == DONE);
            done_r  <= (state_nx_s == DONE);
        end
    end

    // Datapath: latch operands on accept, then shift one result bit per edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r        <= '0;
            b_r        <= '0;
            cnt_r      <= '0;
            borrow_r   <= 1'b0;
            diff_r     <= '0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b1;
        end else if (accept_s) begin
            a_r      <= a;
            b_r      <= b;
            cnt_r    <= '0;
            borrow_r <= 1'b0;
        end else if (state_r == RUN) begin
            diff_r   <= diff_nx_s;
            borrow_r <= cout_s;
            cnt_r    <= cnt_r + CNT_W'(1);
            if (last_bit_s) begin
                // s_bit_s is the result MSB on the final bit.
                overflow_r <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (s_bit_s != a_r[WIDTH-1]);
                zero_r     <= (diff_nx_s == '0);
            end else begin
                overflow_r <= overflow_r;
                zero_r     <= zero_r;
            end
        end else begin
            diff_r <= diff_r;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign diff     = diff_r;
    assign borrow   = borrow_r;
    assign overflow = overflow_r;
    assign zero     = zero_r;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl (WIDTH = 8): directed
// vector table, multi-cycle corner sequences and a randomized back-to-back
// run checked against an arithmetic reference model.
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;
    logic         zero;

    int n_vec;
    int n_err;

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] ediff;
        logic         eborrow;
        logic         eovf;
        logic         ezero;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] d, output logic br,
                                  output logic ov, output logic z);
        int ud;
        int sx;
        int sy;
        int sd;
        ud = int'(x) - int'(y);
        sx = $signed(x);
        sy = $signed(y);
        sd = sx - sy;
        d  = W'(ud);
        br = (ud < 0);
        ov = (sd > 127) || (sd < -128);
        z  = (d == '0);
    endfunction

    // Waits (bounded) for the done pulse; returns edges waited.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done && cyc < 40);
    endtask

    // Presents operands with a one-cycle start pulse, returns latency to done.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, output int cyc);
        start = 1'b1;
        a = x;
        b = y;
        tick();
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_done(cyc);
    endtask

    initial begin
        int cyc;
        int ndone;
        logic [W-1:0] ed;
        logic eb, eo, ez;
        logic [W-1:0] cur_a;
        logic [W-1:0] cur_b;

        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0};

        // Reset values, sampled between edges.
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].va, vecs[i].vb, cyc);
            check("latency", 32'(cyc), 32'(W));
            check("done", 32'(done), 32'd1);
            check("diff", 32'(diff), 32'(vecs[i].ediff));
            check("borrow", 32'(borrow), 32'(vecs[i].eborrow));
            check("overflow", 32'(overflow), 32'(vecs[i].eovf));
            check("zero", 32'(zero), 32'(vecs[i].ezero));
            tick();
            check("done_one_cycle", 32'(done), 32'd0);
            check("busy_idle", 32'(busy), 32'd0);
        end

        // Result holds while idle.
        tick();
        tick();
        tick();
        check("hold_diff", 32'(diff), 32'h0FE);
        check("hold_borrow", 32'(borrow), 32'd0);

        // Start with new operands during RUN is ignored.
        start = 1'b1;
        a = 8'h10;
        b = 8'h01;
        tick();
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        tick();
        tick();
        start = 1'b1;
        a = 8'hFF;
        b = 8'h00;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                ndone++;
                check("ignored_start_diff", 32'(diff), 32'h0F);
            end
            tick();
        end
        check("ignored_start_done_count", 32'(ndone), 32'd1);

        // Asynchronous reset mid-RUN.
        start = 1'b1;
        a = 8'hFF;
        b = 8'h00;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("busy_before_rst", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_diff", 32'(diff), 32'd0);
        check("async_rst_zero", 32'(zero), 32'd1);
        #1;
        rst = 1'b0;
        run_op(8'h40, 8'h41, cyc);
        check("post_rst_latency", 32'(cyc), 32'(W));
        check("post_rst_diff", 32'(diff), 32'hFF);
        check("post_rst_borrow", 32'(borrow), 32'd1);
        tick();

        // Back-to-back random operations with start held high.
        cur_a = W'($urandom);
        cur_b = W'($urandom);
        a = cur_a;
        b = cur_b;
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            wait_done(cyc);
            if (i == 0) begin
                check("rand_first_done", 32'(done), 32'd1);
            end else begin
                check("rand_period", 32'(cyc), 32'(W + 2));
            end
            model(cur_a, cur_b, ed, eb, eo, ez);
            check("rand_diff", 32'(diff), 32'(ed));
            check("rand_borrow", 32'(borrow), 32'(eb));
            check("rand_overflow", 32'(overflow), 32'(eo));
            check("rand_zero", 32'(zero), 32'(ez));
            cur_a = W'($urandom);
            cur_b = W'($urandom);
            if ((i % 16) == 0) begin
                cur_b = cur_a;
            end
            a = cur_a;
            b = cur_b;
        end
        start = 1'b0;
        tick();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
